// File: rtl/ceespu_pkg.sv
// Shared encodings for the ceespu execute stage: ALU opcodes, branch
// conditions, memory access sizes, writeback sources and carry-in sources.
package ceespu_pkg;

  // ALU opcodes
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_OR     = 4'd2;
  localparam logic [3:0] ALU_AND    = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SHL    = 4'd5;
  localparam logic [3:0] ALU_SHR    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_MUL    = 4'd8;
  localparam logic [3:0] ALU_SLT    = 4'd9;
  localparam logic [3:0] ALU_SLTU   = 4'd10;
  localparam logic [3:0] ALU_SEXT8  = 4'd11;
  localparam logic [3:0] ALU_SEXT16 = 4'd12;
  localparam logic [3:0] ALU_PASSB  = 4'd13;
  localparam logic [3:0] ALU_LUI    = 4'd14;
  localparam logic [3:0] ALU_ZERO   = 4'd15;

  // Branch conditions, comparing dataA against dataB
  localparam logic [2:0] BR_EQ    = 3'd0;
  localparam logic [2:0] BR_NE    = 3'd1;
  localparam logic [2:0] BR_LT    = 3'd2;
  localparam logic [2:0] BR_GE    = 3'd3;
  localparam logic [2:0] BR_LTU   = 3'd4;
  localparam logic [2:0] BR_GEU   = 3'd5;
  localparam logic [2:0] BR_ALWAYS = 3'd6;
  localparam logic [2:0] BR_NEVER = 3'd7;

  // Memory access size in selMem[1:0]; selMem[2] is the load sign-extend flag
  localparam logic [1:0] MEM_WORD = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_BYTE = 2'd2;
  localparam logic [1:0] MEM_NONE = 2'd3;
  localparam int         MEM_SIGN_BIT = 2;

  // Writeback source select, interpreted by the writeback stage
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_RSVD = 2'd3;

  // Carry-in source select
  localparam logic [1:0] CIN_ZERO     = 2'd0;
  localparam logic [1:0] CIN_ONE      = 2'd1;
  localparam logic [1:0] CIN_CARRY    = 2'd2;
  localparam logic [1:0] CIN_ZERO_ALT = 2'd3;

  // Multiply sequencing states
  localparam logic [0:0] MUL_IDLE = 1'b0;
  localparam logic [0:0] MUL_DONE = 1'b1;

  // True for the opcodes that run through the adder and update the carry flag
  function automatic logic isAddSub(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/ceespu_alu.sv
// Combinational ALU for the ceespu execute stage. Produces the 32-bit result
// for every opcode and the adder carry-out used for ADD/SUB carry chaining.
module ceespu_alu
  import ceespu_pkg::*;
(
  input  logic [3:0]  aluop,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic        cin,
  output logic [31:0] result,
  output logic        carryOut
);

  logic [32:0] addSum;
  logic [32:0] subSum;
  logic [4:0]  shamt;

  assign shamt = dataB[4:0];

  // Subtraction adds the inverted operand; an incoming carry of 0 means
  // "no borrow pending", which supplies the +1 of the two's complement
  always_comb begin
    addSum = {1'b0, dataA} + {1'b0, dataB} + {32'd0, cin};
    subSum = {1'b0, dataA} + {1'b0, ~dataB} + {32'd0, ~cin};
  end

  // Opcode decode to result and carry-out
  always_comb begin
    result   = 32'd0;
    carryOut = 1'b0;
    case (aluop)
      ALU_ADD: begin
        result   = addSum[31:0];
        carryOut = addSum[32];
      end
      ALU_SUB: begin
        result   = subSum[31:0];
        carryOut = subSum[32];
      end
      ALU_OR:     result = dataA | dataB;
      ALU_AND:    result = dataA & dataB;
      ALU_XOR:    result = dataA ^ dataB;
      ALU_SHL:    result = dataA << shamt;
      ALU_SHR:    result = dataA >> shamt;
      ALU_SRA:    result = $signed(dataA) >>> shamt;
      ALU_MUL:    result = dataA * dataB;
      ALU_SLT:    result = {31'd0, $signed(dataA) < $signed(dataB)};
      ALU_SLTU:   result = {31'd0, dataA < dataB};
      ALU_SEXT8:  result = {{24{dataB[7]}}, dataB[7:0]};
      ALU_SEXT16: result = {{16{dataB[15]}}, dataB[15:0]};
      ALU_PASSB:  result = dataB;
      ALU_LUI:    result = {dataB[15:0], 16'h0000};
      default:    result = 32'd0;
    endcase
  end

endmodule

// File: rtl/ceespu_execute_stage.sv
// ceespu execute stage: ALU with carry chaining, two-cycle multiply with a
// busy handshake, branch condition evaluation, memory address and byte-lane
// generation, and the execute/writeback pipeline register.
module ceespu_execute_stage
  import ceespu_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [3:0]  I_aluop,
  input  logic [31:0] I_dataA,
  input  logic [31:0] I_dataB,
  input  logic [1:0]  I_selCin,
  input  logic        I_we,
  input  logic [4:0]  I_regD,
  input  logic [1:0]  I_selWb,
  input  logic [13:0] I_PC,
  input  logic        I_branch,
  input  logic [2:0]  I_branchop,
  input  logic        I_memE,
  input  logic        I_memWe,
  input  logic [2:0]  I_selMem,
  input  logic [31:0] I_storeData,
  output logic [15:0] O_memAddress,
  output logic        O_memE,
  output logic [3:0]  O_memWe,
  output logic [31:0] O_StoreData,
  output logic        O_branch,
  output logic        O_busy,
  output logic [31:0] O_aluResult,
  output logic        O_we,
  output logic [4:0]  O_regD,
  output logic [1:0]  O_selWb,
  output logic [2:0]  O_selMem,
  output logic [13:0] O_PC
);

  logic        carryFlag;
  logic [0:0]  mulState;
  logic        aluCin;
  logic [31:0] aluResult;
  logic        aluCarryOut;
  logic        mulStall;
  logic        branchTaken;
  logic [15:0] memAddress;
  logic [3:0]  laneMask;

  // Carry-in source selection
  always_comb begin
    aluCin = 1'b0;
    case (I_selCin)
      CIN_ZERO:  aluCin = 1'b0;
      CIN_ONE:   aluCin = 1'b1;
      CIN_CARRY: aluCin = carryFlag;
      default:   aluCin = 1'b0;
    endcase
  end

  ceespu_alu uAlu (
    .aluop    (I_aluop),
    .dataA    (I_dataA),
    .dataB    (I_dataB),
    .cin      (aluCin),
    .result   (aluResult),
    .carryOut (aluCarryOut)
  );

  // A multiply stalls for exactly its first cycle; the second cycle (state
  // DONE) lets the product through, so back-to-back MULs each stall once
  assign mulStall = (I_aluop == ALU_MUL) && (mulState == MUL_IDLE);
  assign O_busy   = mulStall & ~I_rst;

  // Branch condition evaluation on the raw operands
  always_comb begin
    branchTaken = 1'b0;
    case (I_branchop)
      BR_EQ:     branchTaken = (I_dataA == I_dataB);
      BR_NE:     branchTaken = (I_dataA != I_dataB);
      BR_LT:     branchTaken = ($signed(I_dataA) <  $signed(I_dataB));
      BR_GE:     branchTaken = ($signed(I_dataA) >= $signed(I_dataB));
      BR_LTU:    branchTaken = (I_dataA <  I_dataB);
      BR_GEU:    branchTaken = (I_dataA >= I_dataB);
      BR_ALWAYS: branchTaken = 1'b1;
      default:   branchTaken = 1'b0;
    endcase
  end

  assign O_branch = I_branch & branchTaken & ~I_rst;

  // Only the low 16 address bits reach the data memory, so the address adder
  // is kept 16 bits wide
  assign memAddress   = I_dataA[15:0] + I_dataB[15:0];
  assign O_memAddress = memAddress;
  assign O_memE       = I_memE & ~I_rst;

  // Byte-lane enables for the access size at the current address
  always_comb begin
    laneMask = 4'b0000;
    case (I_selMem[1:0])
      MEM_WORD: laneMask = 4'b1111;
      MEM_HALF: laneMask = memAddress[1] ? 4'b1100 : 4'b0011;
      MEM_BYTE: laneMask = 4'b0001 << memAddress[1:0];
      default:  laneMask = 4'b0000;
    endcase
  end

  assign O_memWe = (I_memE & I_memWe & ~I_rst) ? laneMask : 4'b0000;

  // Store data replicated across all lanes so the enabled lane sees it
  // regardless of the address offset
  always_comb begin
    O_StoreData = I_storeData;
    case (I_selMem[1:0])
      MEM_HALF: O_StoreData = {I_storeData[15:0], I_storeData[15:0]};
      MEM_BYTE: O_StoreData = {4{I_storeData[7:0]}};
      default:  O_StoreData = I_storeData;
    endcase
  end

  // Multiply sequencer: IDLE -> DONE on the stall cycle, back to IDLE after
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      mulState <= MUL_IDLE;
    end else if (mulStall) begin
      mulState <= MUL_DONE;
    end else begin
      mulState <= MUL_IDLE;
    end
  end

  // Carry flag follows the adder on every ADD/SUB that commits
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      carryFlag <= 1'b0;
    end else if (!mulStall && isAddSub(I_aluop)) begin
      carryFlag <= aluCarryOut;
    end
  end

  // Execute/writeback register; a multiply stall cycle inserts a bubble
  always_ff @(posedge I_clk) begin
    if (I_rst || mulStall) begin
      O_aluResult <= 32'd0;
      O_we        <= 1'b0;
      O_regD      <= 5'd0;
      O_selWb     <= 2'd0;
      O_selMem    <= 3'd0;
      O_PC        <= 14'd0;
    end else begin
      O_aluResult <= aluResult;
      O_we        <= I_we;
      O_regD      <= I_regD;
      O_selWb     <= I_selWb;
      O_selMem    <= I_selMem;
      O_PC        <= I_PC;
    end
  end

endmodule

// File: tb/tb_ceespu_execute_stage.sv
// Self-checking bench for ceespu_execute_stage: directed vector table,
// hand-written multi-cycle sequences and randomized traffic against a
// behavioural model.
module tb_ceespu_execute_stage;
  import ceespu_pkg::*;

  typedef struct {
    logic        rst;
    logic [3:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  selCin;
    logic        we;
    logic [4:0]  regD;
    logic [1:0]  selWb;
    logic [13:0] pc;
    logic        branch;
    logic [2:0]  branchop;
    logic        memE;
    logic        memWe;
    logic [2:0]  selMem;
    logic [31:0] storeData;
  } stim_t;

  typedef struct {
    stim_t       in;
    logic [31:0] expResult;
  } vec_t;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic [3:0]  I_aluop;
  logic [31:0] I_dataA, I_dataB;
  logic [1:0]  I_selCin;
  logic        I_we;
  logic [4:0]  I_regD;
  logic [1:0]  I_selWb;
  logic [13:0] I_PC;
  logic        I_branch;
  logic [2:0]  I_branchop;
  logic        I_memE, I_memWe;
  logic [2:0]  I_selMem;
  logic [31:0] I_storeData;
  logic [15:0] O_memAddress;
  logic        O_memE;
  logic [3:0]  O_memWe;
  logic [31:0] O_StoreData;
  logic        O_branch, O_busy;
  logic [31:0] O_aluResult;
  logic        O_we;
  logic [4:0]  O_regD;
  logic [1:0]  O_selWb;
  logic [2:0]  O_selMem;
  logic [13:0] O_PC;

  ceespu_execute_stage dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_aluop(I_aluop), .I_dataA(I_dataA),
    .I_dataB(I_dataB), .I_selCin(I_selCin), .I_we(I_we), .I_regD(I_regD),
    .I_selWb(I_selWb), .I_PC(I_PC), .I_branch(I_branch), .I_branchop(I_branchop),
    .I_memE(I_memE), .I_memWe(I_memWe), .I_selMem(I_selMem), .I_storeData(I_storeData),
    .O_memAddress(O_memAddress), .O_memE(O_memE), .O_memWe(O_memWe),
    .O_StoreData(O_StoreData), .O_branch(O_branch), .O_busy(O_busy),
    .O_aluResult(O_aluResult), .O_we(O_we), .O_regD(O_regD), .O_selWb(O_selWb),
    .O_selMem(O_selMem), .O_PC(O_PC)
  );

  always #5 I_clk = ~I_clk;

  int checks = 0;
  int fails  = 0;
  bit carryModel = 1'b0;
  bit mulStalled = 1'b0;
  vec_t vectors[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic stim_t baseStim();
    stim_t s;
    s.rst = 1'b0; s.aluop = ALU_ZERO; s.a = 32'd0; s.b = 32'd0; s.selCin = 2'd0;
    s.we = 1'b1; s.regD = 5'd1; s.selWb = WB_ALU; s.pc = 14'd0; s.branch = 1'b0;
    s.branchop = BR_NEVER; s.memE = 1'b0; s.memWe = 1'b0; s.selMem = 3'd0;
    s.storeData = 32'd0;
    return s;
  endfunction

  function automatic vec_t aluVec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] cin, input logic [31:0] expResult);
    vec_t v;
    v.in = baseStim();
    v.in.aluop = op; v.in.a = a; v.in.b = b; v.in.selCin = cin;
    v.expResult = expResult;
    return v;
  endfunction

  task automatic applyStimulus(input stim_t s);
    I_rst = s.rst; I_aluop = s.aluop; I_dataA = s.a; I_dataB = s.b; I_selCin = s.selCin;
    I_we = s.we; I_regD = s.regD; I_selWb = s.selWb; I_PC = s.pc; I_branch = s.branch;
    I_branchop = s.branchop; I_memE = s.memE; I_memWe = s.memWe; I_selMem = s.selMem;
    I_storeData = s.storeData;
  endtask

  // Reference ALU computed with wide integer arithmetic
  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input bit cin, output bit cout);
    longint unsigned ua, ub, s;
    int sa, sb, sh, v;
    ua = a; ub = b; sa = a; sb = b; sh = int'(b % 32);
    cout = 1'b0;
    case (op)
      4'd0: begin s = ua + ub + (cin ? 1 : 0); cout = (s >> 32) != 0; return 32'(s); end
      4'd1: begin s = ua + (64'hFFFF_FFFF - ub) + (cin ? 0 : 1); cout = (s >> 32) != 0; return 32'(s); end
      4'd2: return a | b;
      4'd3: return a & b;
      4'd4: return a ^ b;
      4'd5: return 32'(ua << sh);
      4'd6: return 32'(ua >> sh);
      4'd7: return 32'(sa >>> sh);
      4'd8: return 32'(ua * ub);
      4'd9: return (sa < sb) ? 32'd1 : 32'd0;
      4'd10: return (ua < ub) ? 32'd1 : 32'd0;
      4'd11: begin v = int'(ub % 256); if (v >= 128) v = v - 256; return 32'(v); end
      4'd12: begin v = int'(ub % 65536); if (v >= 32768) v = v - 65536; return 32'(v); end
      4'd13: return b;
      4'd14: return 32'((ub % 65536) * 65536);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit refBranch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return sa < sb;
      3'd3: return sa >= sb;
      3'd4: return a < b;
      3'd5: return a >= b;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] refLanes(input logic [1:0] size, input int addr);
    case (size)
      2'd0: return 4'hF;
      2'd1: return ((addr % 4) >= 2) ? 4'hC : 4'h3;
      2'd2: return 4'(1 << (addr % 4));
      default: return 4'h0;
    endcase
  endfunction

  // One clock of the stage: combinational outputs, then the registered stage
  task automatic runCycle(input string name);
    bit cinBit, newCarry, expBusy;
    logic [31:0] expRes, expStore;
    int addr;
    cinBit  = (I_selCin == 2'd1) ? 1'b1 : (I_selCin == 2'd2) ? carryModel : 1'b0;
    expRes  = refAlu(I_aluop, I_dataA, I_dataB, cinBit, newCarry);
    expBusy = (I_aluop == 4'd8) && !mulStalled && !I_rst;
    addr    = int'((longint'(I_dataA) + longint'(I_dataB)) % 65536);
    #1;
    checkOutput({name, " busy"}, 32'(O_busy), 32'(expBusy));
    checkOutput({name, " branch"}, 32'(O_branch), 32'(I_branch && !I_rst && refBranch(I_branchop, I_dataA, I_dataB)));
    checkOutput({name, " memE"}, 32'(O_memE), 32'(I_memE && !I_rst));
    checkOutput({name, " memWe"}, 32'(O_memWe),
                32'((I_memE && I_memWe && !I_rst) ? refLanes(I_selMem[1:0], addr) : 4'h0));
    checkOutput({name, " memAddress"}, 32'(O_memAddress), 32'(addr));
    if (I_selMem[1:0] != 2'd3) begin
      expStore = (I_selMem[1:0] == 2'd1) ? (I_storeData % 65536) * 32'h0001_0001 :
                 (I_selMem[1:0] == 2'd2) ? (I_storeData % 256) * 32'h0101_0101 : I_storeData;
      checkOutput({name, " storeData"}, O_StoreData, expStore);
    end
    @(posedge I_clk);
    #1;
    if (I_rst) begin
      checkOutput({name, " rst aluResult"}, O_aluResult, 32'd0);
      checkOutput({name, " rst regs"}, {O_we, O_regD, O_selWb, O_selMem, O_PC}, 32'd0);
      carryModel = 1'b0;
      mulStalled = 1'b0;
    end else if (expBusy) begin
      checkOutput({name, " bubble we"}, 32'(O_we), 32'd0);
      mulStalled = 1'b1;
    end else begin
      checkOutput({name, " aluResult"}, O_aluResult, expRes);
      checkOutput({name, " we"}, 32'(O_we), 32'(I_we));
      checkOutput({name, " regD"}, 32'(O_regD), 32'(I_regD));
      checkOutput({name, " selWb"}, 32'(O_selWb), 32'(I_selWb));
      checkOutput({name, " selMem"}, 32'(O_selMem), 32'(I_selMem));
      checkOutput({name, " PC"}, 32'(O_PC), 32'(I_PC));
      mulStalled = 1'b0;
      if (I_aluop == 4'd0 || I_aluop == 4'd1) carryModel = newCarry;
    end
  endtask

  initial begin
    stim_t s;

    vectors.push_back(aluVec(ALU_ADD,    32'd5,          32'd7,          2'd0, 32'h0000_000C));
    vectors.push_back(aluVec(ALU_ADD,    32'hFFFF_FFFF,  32'd1,          2'd0, 32'h0000_0000));
    vectors.push_back(aluVec(ALU_ADD,    32'd0,          32'd0,          2'd2, 32'h0000_0001));
    vectors.push_back(aluVec(ALU_SUB,    32'd10,         32'd3,          2'd0, 32'h0000_0007));
    vectors.push_back(aluVec(ALU_SUB,    32'd10,         32'd3,          2'd1, 32'h0000_0006));
    vectors.push_back(aluVec(ALU_OR,     32'hF0F0_0000,  32'h0000_0F0F,  2'd0, 32'hF0F0_0F0F));
    vectors.push_back(aluVec(ALU_AND,    32'hFF00_FF00,  32'h0F0F_0F0F,  2'd0, 32'h0F00_0F00));
    vectors.push_back(aluVec(ALU_XOR,    32'hAAAA_5555,  32'hFFFF_0000,  2'd0, 32'h5555_5555));
    vectors.push_back(aluVec(ALU_SHL,    32'd1,          32'd31,         2'd0, 32'h8000_0000));
    vectors.push_back(aluVec(ALU_SHL,    32'd3,          32'h0000_0024,  2'd0, 32'h0000_0030));
    vectors.push_back(aluVec(ALU_SHR,    32'h8000_0000,  32'd4,          2'd0, 32'h0800_0000));
    vectors.push_back(aluVec(ALU_SRA,    32'h8000_0000,  32'd4,          2'd0, 32'hF800_0000));
    vectors.push_back(aluVec(ALU_SLT,    32'hFFFF_FFFE,  32'd1,          2'd0, 32'h0000_0001));
    vectors.push_back(aluVec(ALU_SLTU,   32'hFFFF_FFFE,  32'd1,          2'd0, 32'h0000_0000));
    vectors.push_back(aluVec(ALU_SEXT8,  32'd0,          32'h0000_0080,  2'd0, 32'hFFFF_FF80));
    vectors.push_back(aluVec(ALU_SEXT8,  32'd0,          32'h1234_567F,  2'd0, 32'h0000_007F));
    vectors.push_back(aluVec(ALU_SEXT16, 32'd0,          32'h0000_8001,  2'd0, 32'hFFFF_8001));
    vectors.push_back(aluVec(ALU_PASSB,  32'd9,          32'hDEAD_BEEF,  2'd0, 32'hDEAD_BEEF));
    vectors.push_back(aluVec(ALU_LUI,    32'd0,          32'h0000_1234,  2'd0, 32'h1234_0000));
    vectors.push_back(aluVec(ALU_ZERO,   32'h1234_5678,  32'h9ABC_DEF0,  2'd0, 32'h0000_0000));

    // Reset with every input active
    s = baseStim();
    s.rst = 1'b1; s.aluop = ALU_MUL; s.a = 32'd3; s.b = 32'd5; s.regD = 5'd7; s.selWb = WB_LINK;
    s.pc = 14'h155; s.branch = 1'b1; s.branchop = BR_ALWAYS; s.memE = 1'b1; s.memWe = 1'b1;
    s.selMem = 3'd4; s.storeData = 32'hFFFF_FFFF;
    applyStimulus(s);
    runCycle("reset0");
    runCycle("reset1");

    for (int i = 0; i < vectors.size(); i++) begin
      s = vectors[i].in;
      s.regD = 5'(i); s.pc = 14'(i * 4);
      applyStimulus(s);
      runCycle($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d literal", i), O_aluResult, vectors[i].expResult);
    end

    // Branch conditions on 0xFFFFFFFE vs 1
    s = baseStim();
    s.aluop = ALU_OR; s.a = 32'hFFFF_FFFE; s.b = 32'd1; s.branch = 1'b1; s.branchop = BR_LT;
    s.selWb = WB_LINK; s.regD = 5'd31; s.pc = 14'h2AB;
    applyStimulus(s);
    #1 checkOutput("BLT taken", 32'(O_branch), 32'd1);
    runCycle("blt");
    checkOutput("BLT link PC", 32'(O_PC), 32'h2AB);
    s.branchop = BR_LTU;
    applyStimulus(s);
    #1 checkOutput("BLTU not taken", 32'(O_branch), 32'd0);
    runCycle("bltu");
    s.branchop = BR_NEVER;
    applyStimulus(s);
    #1 checkOutput("branch never", 32'(O_branch), 32'd0);
    runCycle("bnever");

    // Byte and halfword stores, then a load
    s = baseStim();
    s.aluop = ALU_ADD; s.a = 32'h100; s.b = 32'd3; s.memE = 1'b1; s.memWe = 1'b1;
    s.selMem = {1'b0, MEM_BYTE}; s.storeData = 32'h0000_00AB; s.we = 1'b0;
    applyStimulus(s);
    #1;
    checkOutput("SB address", 32'(O_memAddress), 32'h0103);
    checkOutput("SB lanes", 32'(O_memWe), 32'h8);
    checkOutput("SB data", O_StoreData, 32'hABAB_ABAB);
    runCycle("sb");
    s.b = 32'd2; s.selMem = {1'b0, MEM_HALF}; s.storeData = 32'h1234_CDEF;
    applyStimulus(s);
    #1;
    checkOutput("SH lanes", 32'(O_memWe), 32'hC);
    checkOutput("SH data", O_StoreData, 32'hCDEF_CDEF);
    runCycle("sh");
    s.memWe = 1'b0; s.selMem = 3'd4; s.we = 1'b1; s.selWb = WB_MEM;
    applyStimulus(s);
    #1 checkOutput("load lanes", 32'(O_memWe), 32'h0);
    runCycle("lb");

    // Two-cycle multiply
    s = baseStim();
    s.aluop = ALU_MUL; s.a = 32'h0001_0000; s.b = 32'h0001_0001; s.regD = 5'd9;
    applyStimulus(s);
    #1 checkOutput("MUL busy", 32'(O_busy), 32'd1);
    runCycle("mul stall");
    checkOutput("MUL bubble we", 32'(O_we), 32'd0);
    #1 checkOutput("MUL busy drop", 32'(O_busy), 32'd0);
    runCycle("mul done");
    checkOutput("MUL product", O_aluResult, 32'h0001_0000);
    checkOutput("MUL we", 32'(O_we), 32'd1);

    // Back-to-back multiplies each stall once
    s.a = 32'd7; s.b = 32'd6;
    applyStimulus(s);
    runCycle("mulA stall");
    runCycle("mulA done");
    s.a = 32'hFFFF_FFFF; s.b = 32'd2;
    applyStimulus(s);
    #1 checkOutput("mulB busy", 32'(O_busy), 32'd1);
    runCycle("mulB stall");
    runCycle("mulB done");
    checkOutput("mulB product", O_aluResult, 32'hFFFF_FFFE);

    // Reset during the multiply stall aborts it
    s.a = 32'd11; s.b = 32'd13;
    applyStimulus(s);
    runCycle("mulR stall");
    I_rst = 1'b1;
    #1 checkOutput("mulR busy in reset", 32'(O_busy), 32'd0);
    runCycle("mulR reset");
    checkOutput("mulR no write", 32'(O_we), 32'd0);
    checkOutput("mulR result", O_aluResult, 32'd0);
    checkOutput("mulR busy after", 32'(O_busy), 32'd0);
    s = baseStim();
    s.aluop = ALU_PASSB; s.b = 32'h55;
    applyStimulus(s);
    runCycle("post reset");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      s.rst = ($urandom_range(0, 24) == 0);
      s.aluop = 4'($urandom_range(0, 15));
      s.a = $urandom;
      s.b = ($urandom_range(0, 3) == 0) ? s.a : $urandom;
      if ($urandom_range(0, 3) == 0) s.b = 32'($urandom_range(0, 40));
      s.selCin = 2'($urandom_range(0, 3));
      s.we = 1'($urandom_range(0, 1));
      s.regD = 5'($urandom_range(0, 31));
      s.selWb = 2'($urandom_range(0, 3));
      s.pc = 14'($urandom);
      s.branch = 1'($urandom_range(0, 1));
      s.branchop = 3'($urandom_range(0, 7));
      s.memE = 1'($urandom_range(0, 1));
      s.memWe = 1'($urandom_range(0, 1));
      s.selMem = 3'($urandom_range(0, 7));
      s.storeData = $urandom;
      applyStimulus(s);
      runCycle($sformatf("rnd%0d", i));
      if (mulStalled) runCycle($sformatf("rnd%0d mul", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
